spi_reg_responder: RTL and testbench
====================================

// Module: spi_reg_responder
// PURPOSE
//   SPI-slave register responder: the target end of the shared Pmod SPI bus (SCLK/MOSI/MISO/CS).
//   Decodes ADXL362-style transactions: write = 0x0A,addr,data..; read = 0x0B,addr,data..
//   Backs an 8-bit register file also reachable from fabric via a local port.
//   Used as a bus-side sensor emulator/loopback target for our SPI masters; all logic runs on Clock.
// PARAMETERS
//   AW        4   register address width; file holds 2**AW 8-bit registers; addr byte uses low AW bits
// PORTS
//   Clock      in   1   system clock
//   Reset      in   1   asynchronous, active-low reset
//   SCLK       in   1   SPI clock from master, mode 0 (CPOL=0,CPHA=0), async to Clock
//   CS         in   1   chip select, active-low, async
//   MOSI       in   1   master-out data, MSB first
//   MISO       out  1   slave-out data, MSB first
//   MISO_EN    out  1   1 = drive MISO (board tri-state enable); 0 while CS high
//   loc_addr   in   AW  local register address
//   loc_we     in   1   local write strobe
//   loc_wdata  in   8   local write data
//   loc_rdata  out  8   reg[loc_addr], registered, 1-cycle latency
//   spi_wr     out  1   1-cycle pulse per SPI-written data byte
//   spi_waddr  out  AW  address of that write (valid with spi_wr)
//   spi_wdata  out  8   data of that write (valid with spi_wr)
//   busy       out  1   synchronized CS active
// BEHAVIOUR
//   - Reset (async): all regs 0x00; MISO, MISO_EN, spi_wr, busy, loc_rdata, spi_waddr, spi_wdata = 0; state IDLE.
//   - SCLK, CS, MOSI pass 2-flop synchronizers; edges detected on synced SCLK. Requirement: f_SCLK <= f_Clock/8.
//   - MOSI sampled on SCLK rising edge; MISO updated on SCLK falling edge. Bit counter 0..7 per byte.
//   - FSM: IDLE -CS low-> CMD.
//     CMD -8th bit-> ADDR if byte==0x0A or 0x0B, else IGNORE.
//     ADDR -8th bit-> WDATA (write) or RDATA (read); address pointer := byte[AW-1:0].
//   - WDATA: each complete byte writes reg[ptr]; spi_wr pulses 1 Clock after the 8th rising edge; ptr++.
//   - RDATA: on the falling edge following the address byte's 8th rise, shift reg loads reg[ptr].
//     MSB goes to MISO, then ptr++. Each further byte boundary (falling edge after 8th rise) reloads.
//     Value is captured at load time.
//   - Pointer increments modulo 2**AW (15 -> 0 for AW=4); bursts are unbounded.
//   - IGNORE: consume clocks, MISO=0, no writes, until CS high.
//   - MISO_EN = busy; MISO=0 outside RDATA.
//   - CS high at any time (synced) -> IDLE within 3 Clocks. Partial byte discarded, no write, MISO_EN=0.
//   - Same-cycle local and SPI write to the same reg: SPI write wins. Different regs: both complete.
//   - loc_rdata reflects writes from the previous cycle (read-after-write 1 cycle later).
// STRUCTURE
//   - Package spi_resp_pkg: CMD_WR=8'h0A, CMD_RD=8'h0B, state enum {IDLE,CMD,ADDR,WDATA,RDATA,IGNORE}.
//   - Sub-module spi_in_sync: 2-flop sync of SCLK/CS/MOSI plus SCLK rise/fall and CS-fall/rise pulses.
//   - Top: FSM, bit counter, shift regs, pointer, register array.
// TESTING (Clock 100 MHz, SCLK 1 MHz)
//   1. CS low, send 0A 03 5A, CS high -> one spi_wr pulse, waddr=3, wdata=5A.
//      Local read addr 3 -> 5A next cycle.
//   2. Local writes reg14=11, reg15=22, reg0=33; send 0B 0E + 24 clocks -> MISO bytes 11 22 33 (wrap).
//   3. Send 55 02 FF -> no spi_wr, MISO=0 throughout, reg2 unchanged (00).
//   4. Send 0A 04 then 5 bits of data, CS high -> no spi_wr, reg4=00.
//      Following 0B 04 + 8 clocks reads 00.
//   5. SPI write A5 to reg7 lands in the same cycle as loc_we with 3C to reg7 -> reg7=A5.
//   6. Reset low mid-read burst -> MISO, MISO_EN, busy=0 immediately; all regs read 00 after release.

Source files
------------

// File: rtl/spi_resp_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : spi_resp_pkg
// Brief    : Command codes and FSM state encoding for the SPI register responder
// Revision : 1.0 - initial release
// ============================================================================
package spi_resp_pkg;

  localparam logic [7:0] CMD_WR = 8'h0A;
  localparam logic [7:0] CMD_RD = 8'h0B;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CMD    = 3'd1,
    ADDR   = 3'd2,
    WDATA  = 3'd3,
    RDATA  = 3'd4,
    IGNORE = 3'd5
  } state_t;

endpackage
`default_nettype wire

// File: rtl/spi_in_sync.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : spi_in_sync
// Brief    : Two-flop synchronizers for SCLK/CS/MOSI with SCLK and CS edge pulses
// Revision : 1.0 - initial release
// ============================================================================
module spi_in_sync (
  input  logic Clock,
  input  logic Reset,
  input  logic SCLK,
  input  logic CS,
  input  logic MOSI,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic cs_fall,
  output logic cs_rise,
  output logic cs_active,
  output logic mosi_s
);

  // Bit 1 is the synchronized level, bit 2 its previous value for edge detection
  logic [2:0] sclk_q, sclk_d;
  logic [2:0] cs_q, cs_d;
  logic [1:0] mosi_q, mosi_d;

  always_comb begin
    sclk_d = {sclk_q[1:0], SCLK};
    cs_d   = {cs_q[1:0], CS};
    mosi_d = {mosi_q[0], MOSI};
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      sclk_q <= 3'b000;
      cs_q   <= 3'b111;
      mosi_q <= 2'b00;
    end else begin
      sclk_q <= sclk_d;
      cs_q   <= cs_d;
      mosi_q <= mosi_d;
    end
  end

  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = ~sclk_q[1] & sclk_q[2];
  assign cs_fall   = ~cs_q[1] & cs_q[2];
  assign cs_rise   = cs_q[1] & ~cs_q[2];
  assign cs_active = ~cs_q[1];
  assign mosi_s    = mosi_q[1];

endmodule
`default_nettype wire

// File: rtl/spi_reg_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : spi_reg_responder
// Brief    : SPI mode-0 slave decoding 0x0A/0x0B register transactions over a
//            local 8-bit register file shared with a fabric-side port
// Revision : 1.0 - initial release
// ============================================================================
module spi_reg_responder
  import spi_resp_pkg::*;
#(
  parameter int AW = 4
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          SCLK,
  input  logic          CS,
  input  logic          MOSI,
  output logic          MISO,
  output logic          MISO_EN,
  input  logic [AW-1:0] loc_addr,
  input  logic          loc_we,
  input  logic [7:0]    loc_wdata,
  output logic [7:0]    loc_rdata,
  output logic          spi_wr,
  output logic [AW-1:0] spi_waddr,
  output logic [7:0]    spi_wdata,
  output logic          busy
);

  localparam int NREG = 1 << AW;

  logic sclk_rise, sclk_fall, cs_fall, cs_rise, cs_active, mosi_s;

  spi_in_sync u_sync (
    .Clock     (Clock),
    .Reset     (Reset),
    .SCLK      (SCLK),
    .CS        (CS),
    .MOSI      (MOSI),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .cs_fall   (cs_fall),
    .cs_rise   (cs_rise),
    .cs_active (cs_active),
    .mosi_s    (mosi_s)
  );

  state_t        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [6:0]    rx_q, rx_d;
  logic [6:0]    tx_q, tx_d;
  logic          miso_q, miso_d;
  logic          load_pend_q, load_pend_d;
  logic          rd_q, rd_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          spi_wr_q, spi_wr_d;
  logic [AW-1:0] spi_waddr_q, spi_waddr_d;
  logic [7:0]    spi_wdata_q, spi_wdata_d;
  logic [7:0]    loc_rdata_q, loc_rdata_d;
  logic          busy_q, busy_d;
  logic [7:0]    regs_q [NREG];
  logic [7:0]    regs_d [NREG];

  logic [7:0]    rx_byte;
  logic          byte_done;
  logic          spi_we;

  assign rx_byte   = {rx_q, mosi_s};
  assign byte_done = sclk_rise && (bit_cnt_q == 3'd7);

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    miso_d      = miso_q;
    load_pend_d = load_pend_q;
    rd_d        = rd_q;
    ptr_d       = ptr_q;
    spi_wr_d    = 1'b0;
    spi_waddr_d = spi_waddr_q;
    spi_wdata_d = spi_wdata_q;
    busy_d      = cs_active;
    spi_we      = 1'b0;

    if (sclk_rise) begin
      rx_d      = rx_byte[6:0];
      bit_cnt_d = bit_cnt_q + 3'd1;
    end

    case (state_q)
      IDLE: begin
        bit_cnt_d   = 3'd0;
        rx_d        = 7'd0;
        miso_d      = 1'b0;
        load_pend_d = 1'b0;
        if (cs_fall) state_d = CMD;
      end
      CMD: begin
        if (byte_done) begin
          rd_d    = (rx_byte == CMD_RD);
          state_d = ((rx_byte == CMD_WR) || (rx_byte == CMD_RD)) ? ADDR : IGNORE;
        end
      end
      ADDR: begin
        if (byte_done) begin
          ptr_d = rx_byte[AW-1:0];
          if (rd_q) begin
            state_d     = RDATA;
            load_pend_d = 1'b1;
          end else begin
            state_d = WDATA;
          end
        end
      end
      WDATA: begin
        if (byte_done) begin
          spi_we      = 1'b1;
          spi_wr_d    = 1'b1;
          spi_waddr_d = ptr_q;
          spi_wdata_d = rx_byte;
          ptr_d       = ptr_q + AW'(1);
        end
      end
      RDATA: begin
        if (byte_done) load_pend_d = 1'b1;
        // Byte boundary: capture the register now, MSB straight onto MISO
        if (sclk_fall) begin
          if (load_pend_q) begin
            miso_d      = regs_q[ptr_q][7];
            tx_d        = regs_q[ptr_q][6:0];
            ptr_d       = ptr_q + AW'(1);
            load_pend_d = 1'b0;
          end else begin
            miso_d = tx_q[6];
            tx_d   = {tx_q[5:0], 1'b0};
          end
        end
      end
      IGNORE: begin
        miso_d = 1'b0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (!cs_active || cs_rise) begin
      state_d     = IDLE;
      miso_d      = 1'b0;
      load_pend_d = 1'b0;
    end
  end

  // SPI write is applied last so it wins a same-register collision
  always_comb begin
    regs_d = regs_q;
    if (loc_we) regs_d[loc_addr] = loc_wdata;
    if (spi_we) regs_d[ptr_q] = rx_byte;
    loc_rdata_d = regs_q[loc_addr];
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q     <= IDLE;
      bit_cnt_q   <= 3'd0;
      rx_q        <= 7'd0;
      tx_q        <= 7'd0;
      miso_q      <= 1'b0;
      load_pend_q <= 1'b0;
      rd_q        <= 1'b0;
      ptr_q       <= '0;
      spi_wr_q    <= 1'b0;
      spi_waddr_q <= '0;
      spi_wdata_q <= 8'h00;
      loc_rdata_q <= 8'h00;
      busy_q      <= 1'b0;
      regs_q      <= '{default: 8'h00};
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      miso_q      <= miso_d;
      load_pend_q <= load_pend_d;
      rd_q        <= rd_d;
      ptr_q       <= ptr_d;
      spi_wr_q    <= spi_wr_d;
      spi_waddr_q <= spi_waddr_d;
      spi_wdata_q <= spi_wdata_d;
      loc_rdata_q <= loc_rdata_d;
      busy_q      <= busy_d;
      regs_q      <= regs_d;
    end
  end

  assign MISO      = miso_q;
  assign MISO_EN   = busy_q;
  assign busy      = busy_q;
  assign spi_wr    = spi_wr_q;
  assign spi_waddr = spi_waddr_q;
  assign spi_wdata = spi_wdata_q;
  assign loc_rdata = loc_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_reg_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_spi_reg_responder
// Brief    : Directed bench for spi_reg_responder (Clock 100 MHz, SCLK 1 MHz)
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_reg_responder;

  localparam int AW = 4;

  logic          Clock = 1'b0;
  logic          Reset;
  logic          SCLK, CS, MOSI;
  logic          MISO, MISO_EN;
  logic [AW-1:0] loc_addr;
  logic          loc_we;
  logic [7:0]    loc_wdata;
  logic [7:0]    loc_rdata;
  logic          spi_wr;
  logic [AW-1:0] spi_waddr;
  logic [7:0]    spi_wdata;
  logic          busy;

  int            errors = 0;
  int            checks = 0;
  int            wr_count = 0;
  logic [AW-1:0] last_waddr = '0;
  logic [7:0]    last_wdata = 8'h00;
  logic          t5_seen;

  spi_reg_responder #(.AW(AW)) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .SCLK      (SCLK),
    .CS        (CS),
    .MOSI      (MOSI),
    .MISO      (MISO),
    .MISO_EN   (MISO_EN),
    .loc_addr  (loc_addr),
    .loc_we    (loc_we),
    .loc_wdata (loc_wdata),
    .loc_rdata (loc_rdata),
    .spi_wr    (spi_wr),
    .spi_waddr (spi_waddr),
    .spi_wdata (spi_wdata),
    .busy      (busy)
  );

  always #5 Clock = ~Clock;

  always @(negedge Clock) begin
    if (spi_wr) begin
      wr_count   = wr_count + 1;
      last_waddr = spi_waddr;
      last_wdata = spi_wdata;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // SCLK edges land on Clock negedges, well away from the sampling posedge
  task automatic spi_xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      MOSI = tx[7-i];
      #500;
      SCLK = 1'b1;
      rx = {rx[6:0], MISO};
      #500;
      SCLK = 1'b0;
    end
  endtask

  task automatic cs_begin();
    @(negedge Clock);
    CS = 1'b0;
    #500;
  endtask

  task automatic cs_end();
    #500;
    CS = 1'b1;
    #1000;
  endtask

  task automatic loc_write(input logic [AW-1:0] a, input logic [7:0] d);
    @(negedge Clock);
    loc_addr  = a;
    loc_wdata = d;
    loc_we    = 1'b1;
    @(negedge Clock);
    loc_we    = 1'b0;
  endtask

  task automatic loc_read(input logic [AW-1:0] a, output logic [7:0] d);
    @(negedge Clock);
    loc_addr = a;
    @(posedge Clock);
    #1;
    d = loc_rdata;
  endtask

  logic [7:0] rx, rd;
  logic [7:0] rx_or;

  initial begin
    Reset = 1'b1; SCLK = 1'b0; CS = 1'b1; MOSI = 1'b0;
    loc_addr = '0; loc_we = 1'b0; loc_wdata = 8'h00;
    #2 Reset = 1'b0;
    #50;
    chk("rst_miso", MISO, 0);
    chk("rst_miso_en", MISO_EN, 0);
    chk("rst_busy", busy, 0);
    chk("rst_spi_wr", spi_wr, 0);
    chk("rst_loc_rdata", loc_rdata, 8'h00);
    chk("rst_spi_wdata", spi_wdata, 8'h00);
    @(negedge Clock);
    Reset = 1'b1;
    repeat (5) @(negedge Clock);

    // 1: single SPI write
    cs_begin();
    chk("t1_busy", busy, 1);
    chk("t1_miso_en", MISO_EN, 1);
    spi_xfer(8'h0A, 8, rx);
    spi_xfer(8'h03, 8, rx);
    spi_xfer(8'h5A, 8, rx);
    cs_end();
    chk("t1_wr_count", wr_count, 1);
    chk("t1_waddr", last_waddr, 3);
    chk("t1_wdata", last_wdata, 8'h5A);
    chk("t1_busy_off", busy, 0);
    loc_read(4'd3, rd);
    chk("t1_loc_rd3", rd, 8'h5A);

    // 2: burst read wrapping 14 -> 15 -> 0
    loc_write(4'd14, 8'h11);
    loc_write(4'd15, 8'h22);
    loc_write(4'd0, 8'h33);
    cs_begin();
    spi_xfer(8'h0B, 8, rx);
    chk("t2_miso_cmd", rx, 8'h00);
    spi_xfer(8'h0E, 8, rx);
    chk("t2_miso_addr", rx, 8'h00);
    spi_xfer(8'h00, 8, rx);
    chk("t2_rd_byte0", rx, 8'h11);
    spi_xfer(8'h00, 8, rx);
    chk("t2_rd_byte1", rx, 8'h22);
    spi_xfer(8'h00, 8, rx);
    chk("t2_rd_byte2", rx, 8'h33);
    cs_end();
    chk("t2_wr_count", wr_count, 1);

    // 3: unknown command is ignored
    cs_begin();
    rx_or = 8'h00;
    spi_xfer(8'h55, 8, rx); rx_or |= rx;
    spi_xfer(8'h02, 8, rx); rx_or |= rx;
    spi_xfer(8'hFF, 8, rx); rx_or |= rx;
    cs_end();
    chk("t3_miso_zero", rx_or, 8'h00);
    chk("t3_wr_count", wr_count, 1);
    loc_read(4'd2, rd);
    chk("t3_reg2", rd, 8'h00);

    // 4: partial data byte is discarded
    cs_begin();
    spi_xfer(8'h0A, 8, rx);
    spi_xfer(8'h04, 8, rx);
    spi_xfer(8'hFF, 5, rx);
    cs_end();
    chk("t4_wr_count", wr_count, 1);
    chk("t4_miso_en_off", MISO_EN, 0);
    loc_read(4'd4, rd);
    chk("t4_reg4_local", rd, 8'h00);
    cs_begin();
    spi_xfer(8'h0B, 8, rx);
    spi_xfer(8'h04, 8, rx);
    spi_xfer(8'h00, 8, rx);
    cs_end();
    chk("t4_reg4_spi", rx, 8'h00);

    // 5: SPI and local write collide on reg7; SPI must win
    @(negedge Clock);
    loc_addr = 4'd7; loc_wdata = 8'h3C; loc_we = 1'b1;
    cs_begin();
    spi_xfer(8'h0A, 8, rx);
    spi_xfer(8'h07, 8, rx);
    t5_seen = 1'b0;
    fork
      spi_xfer(8'hA5, 8, rx);
      begin
        for (int k = 0; k < 2000; k++) begin
          @(negedge Clock);
          if (spi_wr) begin
            t5_seen = 1'b1;
            loc_we  = 1'b0;
            break;
          end
        end
      end
    join
    loc_we = 1'b0;
    cs_end();
    chk("t5_wr_seen", t5_seen, 1);
    chk("t5_wr_count", wr_count, 2);
    chk("t5_waddr", last_waddr, 7);
    chk("t5_wdata", last_wdata, 8'hA5);
    loc_read(4'd7, rd);
    chk("t5_reg7", rd, 8'hA5);

    // 6: asynchronous reset in the middle of a read burst
    cs_begin();
    spi_xfer(8'h0B, 8, rx);
    spi_xfer(8'h07, 8, rx);
    #100;
    chk("t6_miso_pre", MISO, 1);
    Reset = 1'b0;
    #1;
    chk("t6_miso", MISO, 0);
    chk("t6_miso_en", MISO_EN, 0);
    chk("t6_busy", busy, 0);
    CS = 1'b1;
    #1000;
    @(negedge Clock);
    Reset = 1'b1;
    repeat (5) @(negedge Clock);
    loc_read(4'd3, rd);  chk("t6_reg3", rd, 8'h00);
    loc_read(4'd7, rd);  chk("t6_reg7", rd, 8'h00);
    loc_read(4'd14, rd); chk("t6_reg14", rd, 8'h00);
    loc_read(4'd15, rd); chk("t6_reg15", rd, 8'h00);
    loc_read(4'd0, rd);  chk("t6_reg0", rd, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
